switchbox_cfg_loader: RTL and testbench

//  Serial configuration loader for one 5x4 switch-box routing matrix. Accepts a
//  bit-serial config stream, assembles the 18 SELW-bit select words (5 top,
//  5 bottom, 4 left, 4 right) in a shadow register, then commits all of them in
//  one cycle to the flattened buses that drive the matrix select inputs.

---
 rtl/switchbox_cfg_loader.sv | 180 ++++++++++++++++++
 tb/tb_switchbox_cfg_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switchbox_cfg_loader.sv
// Purpose: bit-serial loader for a 5x4 switch-box; shadow-assembles 18 select words, commits atomically (optional trailer check under CFG_CHK_EN).
// Latency: last accepted bit in cycle N -> sel_* and cfg_done/cfg_err valid in cycle N+1, back in IDLE at N+2.
// Backpressure: cfg_ready high only in LOAD/CHECK; cfg_valid low simply stalls the stream, cfg_start restarts it.
module switchbox_cfg_loader #(
    parameter int NTB  = 5,
    parameter int NLR  = 4,
    parameter int SELW = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_valid,
    input  logic                  cfg_bit,
    output logic                  cfg_ready,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic [NTB*SELW-1:0]   sel_top,
    output logic [NTB*SELW-1:0]   sel_bottom,
    output logic [NLR*SELW-1:0]   sel_left,
    output logic [NLR*SELW-1:0]   sel_right
);

    localparam int NW  = 2*NTB + 2*NLR;
    localparam int WCW = $clog2(NW);
    localparam int BCW = $clog2(SELW);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_CHECK  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SELW-1:0]     shadow_q   [NW];
    logic [SELW-1:0]     shadow_nxt [NW];
    logic [NW*SELW-1:0]  shadow_flat;
    logic [BCW-1:0]      bit_cnt_q;
    logic [WCW-1:0]      word_cnt_q;
    logic                accept;
    logic                last_bit;
    logic                last_word;
    logic                commit_fire;
    logic                chk_ok;
    logic                restart;

    assign cfg_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign cfg_busy  = cfg_ready;
    // A start pulse wins over any bit presented in the same cycle.
    assign accept    = cfg_valid && cfg_ready && !cfg_start;
    assign restart   = cfg_start && (state_q != S_COMMIT);
    assign last_bit  = (bit_cnt_q == BCW'(SELW-1));
    assign last_word = (word_cnt_q == WCW'(NW-1));

`ifdef CFG_CHK_EN
    logic [SELW-1:0] trailer_q;
    logic [SELW-1:0] trailer_nxt;
    logic [SELW-1:0] payload_xor;

    assign trailer_nxt = {trailer_q[SELW-2:0], cfg_bit};
    assign commit_fire = accept && last_bit && (state_q == S_CHECK);

    always_comb begin
        payload_xor = '0;
        for (int k = 0; k < NW; k++) begin
            payload_xor = payload_xor ^ shadow_q[k];
        end
    end

    assign chk_ok = (trailer_nxt == payload_xor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trailer_q <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= commit_fire && !chk_ok;
            if (restart) begin
                trailer_q <= '0;
            end else if (accept && (state_q == S_CHECK)) begin
                trailer_q <= trailer_nxt;
            end
        end
    end
`else
    assign commit_fire = accept && last_bit && last_word && (state_q == S_LOAD);
    assign chk_ok      = 1'b1;
    assign cfg_err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (cfg_start) begin
                    state_d = S_LOAD;
                end else if (accept && last_bit && last_word) begin
`ifdef CFG_CHK_EN
                    state_d = S_CHECK;
`else
                    state_d = S_COMMIT;
`endif
                end
            end
`ifdef CFG_CHK_EN
            S_CHECK: begin
                if (cfg_start) begin
                    state_d = S_LOAD;
                end else if (accept && last_bit) begin
                    state_d = S_COMMIT;
                end
            end
`endif
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next shadow includes the bit being accepted, so the commit edge sees the full word set.
    always_comb begin
        shadow_nxt = shadow_q;
        if (accept && (state_q == S_LOAD)) begin
            shadow_nxt[word_cnt_q] = {shadow_q[word_cnt_q][SELW-2:0], cfg_bit};
        end
    end

    always_comb begin
        shadow_flat = '0;
        for (int k = 0; k < NW; k++) begin
            shadow_flat[k*SELW +: SELW] = shadow_nxt[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            cfg_done   <= 1'b0;
            sel_top    <= '0;
            sel_bottom <= '0;
            sel_left   <= '0;
            sel_right  <= '0;
            for (int k = 0; k < NW; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cfg_done <= commit_fire && chk_ok;
            if (restart) begin
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
                for (int k = 0; k < NW; k++) begin
                    shadow_q[k] <= '0;
                end
            end else if (accept) begin
                shadow_q <= shadow_nxt;
                if (last_bit) begin
                    bit_cnt_q <= '0;
                    if ((state_q == S_LOAD) && !last_word) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
            if (commit_fire && chk_ok) begin
                sel_top    <= shadow_flat[0 +: NTB*SELW];
                sel_bottom <= shadow_flat[NTB*SELW +: NTB*SELW];
                sel_left   <= shadow_flat[2*NTB*SELW +: NLR*SELW];
                sel_right  <= shadow_flat[(2*NTB+NLR)*SELW +: NLR*SELW];
            end
        end
    end

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Randomized self-checking bench for switchbox_cfg_loader; reference keeps the committed word list.
module tb_switchbox_cfg_loader;

    localparam int NTB  = 5;
    localparam int NLR  = 4;
    localparam int SELW = 6;
    localparam int NW   = 18;
    localparam int NB   = NW*SELW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cfg_start = 1'b0;
    logic cfg_valid = 1'b0;
    logic cfg_bit = 1'b0;
    logic cfg_ready, cfg_busy, cfg_done, cfg_err;
    logic [NTB*SELW-1:0] sel_top, sel_bottom;
    logic [NLR*SELW-1:0] sel_left, sel_right;

    switchbox_cfg_loader #(.NTB(NTB), .NLR(NLR), .SELW(SELW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_bit(cfg_bit), .cfg_ready(cfg_ready), .cfg_busy(cfg_busy),
        .cfg_done(cfg_done), .cfg_err(cfg_err), .sel_top(sel_top),
        .sel_bottom(sel_bottom), .sel_left(sel_left), .sel_right(sel_right)
    );

    always #5 clk = ~clk;

    wire [NB-1:0] sel_all = {sel_right, sel_left, sel_bottom, sel_top};

    int checks = 0;
    int errors = 0;
    logic [SELW-1:0] pay [NW];
    logic [SELW-1:0] committed [NW];
    bit stream [$];
    int busy_low;
    logic obs_done1, obs_err1, obs_done2, obs_err2, obs_busy2;
    logic [NB-1:0] obs_sel1;

    // Word k of the load order (top, bottom, left, right) lands at bits [k*SELW +: SELW] of sel_all.
    function automatic logic [NB-1:0] expect_bus();
        logic [NB-1:0] v;
        v = '0;
        for (int k = 0; k < NW; k++) v[k*SELW +: SELW] = committed[k];
        return v;
    endfunction

    function automatic logic [SELW-1:0] pay_xor();
        logic [SELW-1:0] x;
        x = '0;
        for (int k = 0; k < NW; k++) x ^= pay[k];
        return x;
    endfunction

    task automatic build_stream(input logic [SELW-1:0] tmask);
        logic [SELW-1:0] t;
        stream.delete();
        for (int w = 0; w < NW; w++)
            for (int b = SELW-1; b >= 0; b--) stream.push_back(pay[w][b]);
        t = pay_xor() ^ tmask;
`ifdef CFG_CHK_EN
        for (int b = SELW-1; b >= 0; b--) stream.push_back(t[b]);
`endif
    endtask

    task automatic start_pulse(input bit with_bit);
        cfg_start = 1'b1;
        cfg_valid = with_bit;
        cfg_bit   = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic send_bits(input int first, input int last_excl, input bit gaps);
        int g;
        for (int i = first; i < last_excl; i++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                cfg_valid = 1'b0;
                @(negedge clk); if (!cfg_busy) busy_low++;
                @(posedge clk); #1;
            end
            cfg_valid = 1'b1;
            cfg_bit   = stream[i];
            @(negedge clk); if (!cfg_busy) busy_low++;
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic observe_commit();
        @(negedge clk);
        obs_done1 = cfg_done; obs_err1 = cfg_err; obs_sel1 = sel_all;
        @(posedge clk); #1;
        @(negedge clk);
        obs_done2 = cfg_done; obs_err2 = cfg_err; obs_busy2 = cfg_busy;
        @(posedge clk); #1;
    endtask

    task automatic do_load(input bit gaps, input logic [SELW-1:0] tmask);
        build_stream(tmask);
        start_pulse(1'b0);
        busy_low = 0;
        send_bits(0, stream.size(), gaps);
        observe_commit();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        checks++; if (sel_all !== '0) begin errors++; $display("FAIL reset_sel: got %h expected 0", sel_all); end
        checks++; if ({cfg_ready, cfg_busy, cfg_done, cfg_err} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {cfg_ready, cfg_busy, cfg_done, cfg_err}); end
        for (int k = 0; k < NW; k++) committed[k] = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({cfg_ready, cfg_busy} !== 2'b00) begin
            errors++; $display("FAIL reset_idle: got %b expected 00", {cfg_ready, cfg_busy}); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_load();
        for (int k = 0; k < NW; k++) pay[k] = '0;
        pay[0] = 6'b001_011;
        do_load(1'b0, '0);
        for (int k = 0; k < NW; k++) committed[k] = pay[k];
        checks++; if (obs_done1 !== 1'b1) begin errors++; $display("FAIL full_done: got %b expected 1", obs_done1); end
        checks++; if (obs_err1 !== 1'b0) begin errors++; $display("FAIL full_err: got %b expected 0", obs_err1); end
        checks++; if (obs_sel1 !== expect_bus()) begin errors++; $display("FAIL full_sel: got %h expected %h", obs_sel1, expect_bus()); end
        checks++; if (obs_sel1[5:0] !== 6'h0B) begin errors++; $display("FAIL full_top0: got %h expected 0b", obs_sel1[5:0]); end
        checks++; if ({obs_done2, obs_busy2} !== 2'b00) begin errors++; $display("FAIL full_pulse: got %b expected 00", {obs_done2, obs_busy2}); end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < NW; k++) pay[k] = '0;
        pay[0] = 6'b001_011;
        do_load(1'b1, '0);
        for (int k = 0; k < NW; k++) committed[k] = pay[k];
        checks++; if (obs_done1 !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", obs_done1); end
        checks++; if (obs_sel1 !== expect_bus()) begin errors++; $display("FAIL bp_sel: got %h expected %h", obs_sel1, expect_bus()); end
        checks++; if (busy_low !== 0) begin errors++; $display("FAIL bp_busy: got %0d idle cycles expected 0", busy_low); end
        checks++; if (obs_done2 !== 1'b0) begin errors++; $display("FAIL bp_pulse: got %b expected 0", obs_done2); end
    endtask

    task automatic test_abort();
        for (int k = 0; k < NW; k++) pay[k] = 6'($urandom);
        build_stream('0);
        start_pulse(1'b0);
        send_bits(0, 40, 1'b1);
        @(negedge clk);
        checks++; if (sel_all !== expect_bus()) begin errors++; $display("FAIL abort_hold: got %h expected %h", sel_all, expect_bus()); end
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b expected 1", cfg_busy); end
        @(posedge clk); #1;
        for (int k = 0; k < NW; k++) pay[k] = '0;
        pay[NW-1] = 6'h1A;
        build_stream('0);
        start_pulse(1'b1);
        send_bits(0, stream.size(), 1'b0);
        observe_commit();
        for (int k = 0; k < NW; k++) committed[k] = pay[k];
        checks++; if (obs_done1 !== 1'b1) begin errors++; $display("FAIL abort_done: got %b expected 1", obs_done1); end
        checks++; if (obs_sel1 !== expect_bus()) begin errors++; $display("FAIL abort_sel: got %h expected %h", obs_sel1, expect_bus()); end
        checks++; if (obs_sel1[107:102] !== 6'h1A) begin errors++; $display("FAIL abort_right3: got %h expected 1a", obs_sel1[107:102]); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NW; k++) pay[k] = 6'h11;
        do_load(1'b0, '0);
        for (int k = 0; k < NW; k++) committed[k] = pay[k];
        checks++; if (obs_sel1 !== expect_bus()) begin errors++; $display("FAIL b2b_first: got %h expected %h", obs_sel1, expect_bus()); end
        for (int k = 0; k < NW; k++) pay[k] = 6'h22;
        build_stream('0);
        start_pulse(1'b0);
        send_bits(0, stream.size()-1, 1'b1);
        @(negedge clk);
        checks++; if (sel_all !== expect_bus()) begin errors++; $display("FAIL b2b_hold: got %h expected %h", sel_all, expect_bus()); end
        @(posedge clk); #1;
        send_bits(stream.size()-1, stream.size(), 1'b0);
        observe_commit();
        for (int k = 0; k < NW; k++) committed[k] = pay[k];
        checks++; if (obs_done1 !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", obs_done1); end
        checks++; if (obs_sel1 !== expect_bus()) begin errors++; $display("FAIL b2b_second: got %h expected %h", obs_sel1, expect_bus()); end
    endtask

`ifdef CFG_CHK_EN
    task automatic test_checksum();
        for (int k = 0; k < NW; k++) pay[k] = 6'($urandom);
        do_load(1'b1, '0);
        for (int k = 0; k < NW; k++) committed[k] = pay[k];
        checks++; if ({obs_done1, obs_err1} !== 2'b10) begin errors++; $display("FAIL chk_good: got done,err=%b expected 10", {obs_done1, obs_err1}); end
        checks++; if (obs_sel1 !== expect_bus()) begin errors++; $display("FAIL chk_good_sel: got %h expected %h", obs_sel1, expect_bus()); end
        for (int k = 0; k < NW; k++) pay[k] = 6'($urandom);
        do_load(1'b0, 6'h01);
        checks++; if ({obs_done1, obs_err1} !== 2'b01) begin errors++; $display("FAIL chk_bad: got done,err=%b expected 01", {obs_done1, obs_err1}); end
        checks++; if (obs_sel1 !== expect_bus()) begin errors++; $display("FAIL chk_bad_sel: got %h expected %h", obs_sel1, expect_bus()); end
        checks++; if ({obs_done2, obs_err2} !== 2'b00) begin errors++; $display("FAIL chk_pulse: got %b expected 00", {obs_done2, obs_err2}); end
    endtask
`endif

    task automatic test_random();
        logic [SELW-1:0] tmask;
        bit ok;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NW; k++) pay[k] = 6'($urandom);
            tmask = '0;
`ifdef CFG_CHK_EN
            if ($urandom_range(0, 2) == 0) tmask = 6'($urandom_range(1, 63));
`endif
            ok = (tmask == '0);
            do_load(1'($urandom_range(0, 1)), tmask);
            if (ok) for (int k = 0; k < NW; k++) committed[k] = pay[k];
            checks++; if ({obs_done1, obs_err1} !== {ok, ~ok}) begin
                errors++; $display("FAIL rand_flags[%0d]: got %b expected %b", it, {obs_done1, obs_err1}, {ok, ~ok}); end
            checks++; if (obs_sel1 !== expect_bus()) begin
                errors++; $display("FAIL rand_sel[%0d]: got %h expected %h", it, obs_sel1, expect_bus()); end
        end
    endtask

    task automatic test_reset_midload();
        for (int k = 0; k < NW; k++) pay[k] = 6'($urandom);
        build_stream('0);
        start_pulse(1'b0);
        send_bits(0, 20, 1'b0);
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < NW; k++) committed[k] = '0;
        checks++; if (sel_all !== expect_bus()) begin errors++; $display("FAIL midrst_sel: got %h expected 0", sel_all); end
        checks++; if ({cfg_busy, cfg_ready} !== 2'b00) begin errors++; $display("FAIL midrst_busy: got %b expected 00", {cfg_busy, cfg_ready}); end
        @(posedge clk); #1 rst_n = 1'b1;
        busy_low = 0;
        cfg_valid = 1'b1; cfg_bit = 1'b1;
        repeat (3) begin
            @(negedge clk); if (!cfg_busy && !cfg_ready) busy_low++;
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        checks++; if (busy_low !== 3) begin errors++; $display("FAIL midrst_idle: got %0d idle cycles expected 3", busy_low); end
        do_load(1'b0, '0);
        for (int k = 0; k < NW; k++) committed[k] = pay[k];
        checks++; if (obs_done1 !== 1'b1) begin errors++; $display("FAIL midrst_reload_done: got %b expected 1", obs_done1); end
        checks++; if (obs_sel1 !== expect_bus()) begin errors++; $display("FAIL midrst_reload_sel: got %h expected %h", obs_sel1, expect_bus()); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_backpressure();
        test_abort();
        test_back_to_back();
`ifdef CFG_CHK_EN
        test_checksum();
`endif
        test_random();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
